pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline control responder for the 3PA 5-stage core. It consumes the hazard requests produced upstream: the load-use Need_Stall, EX branch resolution, ID jump, data-memory wait, and halt. It turns them into per-stage register enables and flushes (bubbles) plus the PC enable. A small state machine covers multi-cycle events: the one-shot load-use bubble, the memory wait with timeout, and halt/resume.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles before the access is abandoned; 0 = no timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
Need_Stall  in  1  load-use hazard: load in EX/MEM, dependent instruction in ID/EX.
Branch_Taken  in  1  branch in ID/EX resolved taken this cycle.
Jump  in  1  jump decoded in IF/ID.
Mem_Req  in  1  EX/MEM holds a data-memory access (EXmem__MemEnable).
Mem_Ack  in  1  data memory completes the access this cycle.
Halt  in  1  halt instruction in ID/EX.
Resume  in  1  external restart pulse.
PC_En  out  1  PC register load enable.
IFid__En, IDex__En, EXmem__En, MEMwb__En  out  1 each  stage register enables.
IFid__Flush, IDex__Flush, EXmem__Flush  out  1 each  load bubble (NOP, all write enables 0) at the next edge; Flush overrides En.
Halted  out  1  core halted.
Mem_Err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- States: RUN, LOADUSE, MEMWAIT, HALTED. The state register is cleared asynchronously to RUN. The wait counter is cleared asynchronously to 0.
- Outputs are combinational from state and inputs, so the response lands at the same-cycle edge.
- While rst is high: every En=0, every Flush=1, Halted=0, Mem_Err=0.
- Default in RUN with no event: every En=1, every Flush=0.
- RUN evaluates requests in this priority order, highest first:
  1. Mem_Req && !Mem_Ack: freeze. All En=0, no flush. Next state MEMWAIT, counter set to 1.
  2. Need_Stall: PC_En=IFid__En=IDex__En=0, EXmem__Flush=1, MEMwb__En=1. Next state LOADUSE.
  3. Branch_Taken: PC_En=1 (target), IFid__Flush=1, IDex__Flush=1. Stay in RUN.
  4. Halt: PC_En=0, IFid__En=0, IDex__Flush=1, EX/MEM and MEM/WB advance. Next state HALTED.
  5. Jump: PC_En=1, IFid__Flush=1. Stay in RUN.
- Priority consequences:
  - Branch_Taken together with Jump: the branch wins; the jump is discarded by the IF/ID flush.
  - Need_Stall wins over Branch_Taken: branch resolution with a stale operand is invalid, and the branch re-resolves next cycle.
- LOADUSE:
  - Behaves as RUN except Need_Stall is ignored, which guarantees at most one bubble per load.
  - Next state is RUN unless a MEMWAIT or HALTED entry occurs.
- MEMWAIT:
  - All En=0 while Mem_Ack is low; the counter increments each cycle.
  - On Mem_Ack: outputs follow RUN rules for that cycle, excluding rule 1. Next state RUN, counter 0.
  - Timeout when MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT without ack: Mem_Err=1 for that cycle, EXmem__Flush=1 (access dropped), PC_En, IFid__En and IDex__En stay 0. Next state RUN.
  - Branch_Taken, Jump and Halt held during the wait act on the release cycle.
- HALTED:
  - PC_En=0, IFid__En=0, IDex__Flush=1; EX/MEM and MEM/WB stay enabled, so the pipe drains. Halted=1.
  - Resume: next state RUN, and Halted drops the following cycle.
  - Mem_Req && !Mem_Ack in HALTED freezes EX/MEM and MEM/WB but does not leave HALTED.
- Reset asserted mid-wait or mid-halt returns immediately to RUN with the counter at 0. No pending event is retained.

Optional Feature:
PIPE_CTRL_PERF_EN: adds outputs Stall_Cnt[31:0] and Flush_Cnt[31:0], both cleared by rst.
- Stall_Cnt increments every cycle PC_En=0 outside HALTED.
- Flush_Cnt increments every cycle IFid__Flush=1.
- Both saturate at 32'hFFFFFFFF.
- Without the macro these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Need_Stall=1 for 2 cycles from RUN -> cycle 1: PC_En=0, EXmem__Flush=1, MEMwb__En=1; cycle 2 (LOADUSE): all En=1, no flush. Exactly one bubble.
2. Mem_Req=1, Mem_Ack=0 for 3 cycles, then Mem_Ack=1 -> all En=0 for 3 cycles, then all En=1 and state RUN; Mem_Err stays 0.
3. MEM_TIMEOUT=4, Mem_Ack never -> Mem_Err pulses once on the 5th frozen cycle with EXmem__Flush=1, then RUN.
4. Need_Stall=1 and Branch_Taken=1 together -> stall response, no IFid__Flush. Next cycle with Branch_Taken=1: IFid__Flush=IDex__Flush=1, PC_En=1.
5. Halt=1 -> Halted=1 next cycle, PC_En=0, IDex__Flush=1 held for 10 cycles. Resume pulse -> RUN, Halted=0 the cycle after.
6. rst asserted mid-MEMWAIT (asynchronous, off clock edge) -> outputs go immediately to all En=0 / Flush=1; after release: RUN, counter 0, and with PIPE_CTRL_PERF_EN both counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl -- pipeline control responder for the 3PA 5-stage core.
//
// Turns the upstream hazard requests (load-use stall, branch taken, jump,
// data-memory wait, halt) into per-stage register enables, bubble flushes and
// the PC enable. A small FSM covers the multi-cycle cases: the single
// load-use bubble, the memory wait with optional timeout, and halt/resume.
// Outputs are combinational from state and inputs, so they act at the next
// clock edge.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive wait cycles before the access is dropped
//                (0 = wait forever)
//   CNT_W        wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   Need_Stall                     load-use hazard
//   Branch_Taken                   branch in ID/EX resolved taken
//   Jump                           jump decoded in IF/ID
//   Mem_Req, Mem_Ack               data-memory access pending / completing
//   Halt, Resume                   halt instruction in ID/EX / restart pulse
//   PC_En                          PC load enable
//   IFid__En .. MEMwb__En          stage register enables
//   IFid__Flush .. EXmem__Flush    load a bubble at the next edge (beats En)
//   Halted                         core halted
//   Mem_Err                        one-cycle pulse on memory timeout
//
// Optional build macro PIPE_CTRL_PERF_EN adds saturating 32-bit counters
// Stall_Cnt (PC held outside HALTED) and Flush_Cnt (IF/ID flushed).
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Need_Stall,
    input  logic        Branch_Taken,
    input  logic        Jump,
    input  logic        Mem_Req,
    input  logic        Mem_Ack,
    input  logic        Halt,
    input  logic        Resume,
    output logic        PC_En,
    output logic        IFid__En,
    output logic        IDex__En,
    output logic        EXmem__En,
    output logic        MEMwb__En,
    output logic        IFid__Flush,
    output logic        IDex__Flush,
    output logic        EXmem__Flush,
    output logic        Halted,
    output logic        Mem_Err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] Stall_Cnt,
    output logic [31:0] Flush_Cnt
`endif
);

    typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT, HALTED} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    // Unmasked responses; rst is applied only at the output boundary so the
    // reset net never feeds flop data inputs.
    logic pc_en_int, if_en_int, id_en_int, ex_en_int, wb_en_int;
    logic if_fl_int, id_fl_int, ex_fl_int, err_int;
    logic run_eval, stall_ok, timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_reg == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_en_int  = 1'b1;
        if_en_int  = 1'b1;
        id_en_int  = 1'b1;
        ex_en_int  = 1'b1;
        wb_en_int  = 1'b1;
        if_fl_int  = 1'b0;
        id_fl_int  = 1'b0;
        ex_fl_int  = 1'b0;
        err_int    = 1'b0;
        run_eval   = 1'b0;
        stall_ok   = 1'b0;

        case (state_reg)
            RUN: begin
                run_eval = 1'b1;
                stall_ok = 1'b1;
            end
            // The dependent instruction already got its bubble; ignoring a
            // still-asserted Need_Stall keeps it to one bubble per load.
            LOADUSE: begin
                run_eval = 1'b1;
            end
            MEMWAIT: begin
                if (Mem_Ack) begin
                    // Release cycle: requests held during the wait act now.
                    run_eval = 1'b1;
                    stall_ok = 1'b1;
                    cnt_next = '0;
                end else begin
                    pc_en_int = 1'b0;
                    if_en_int = 1'b0;
                    id_en_int = 1'b0;
                    ex_en_int = 1'b0;
                    wb_en_int = 1'b0;
                    if (timeout_hit) begin
                        // Abandon the access: bubble EX/MEM, upstream holds.
                        err_int    = 1'b1;
                        ex_fl_int  = 1'b1;
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            HALTED: begin
                // Front end frozen, back end drains.
                pc_en_int = 1'b0;
                if_en_int = 1'b0;
                id_fl_int = 1'b1;
                if (Mem_Req && !Mem_Ack) begin
                    ex_en_int = 1'b0;
                    wb_en_int = 1'b0;
                end
                if (Resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (run_eval) begin
            if (Mem_Req && !Mem_Ack) begin
                pc_en_int  = 1'b0;
                if_en_int  = 1'b0;
                id_en_int  = 1'b0;
                ex_en_int  = 1'b0;
                wb_en_int  = 1'b0;
                state_next = MEMWAIT;
                cnt_next   = CNT_W'(1);
            end else if (stall_ok && Need_Stall) begin
                // Outranks Branch_Taken: a branch resolved on a stale operand
                // must re-resolve next cycle.
                pc_en_int  = 1'b0;
                if_en_int  = 1'b0;
                id_en_int  = 1'b0;
                ex_fl_int  = 1'b1;
                state_next = LOADUSE;
            end else if (Branch_Taken) begin
                // Also discards any jump sitting in IF/ID.
                if_fl_int  = 1'b1;
                id_fl_int  = 1'b1;
                state_next = RUN;
            end else if (Halt) begin
                pc_en_int  = 1'b0;
                if_en_int  = 1'b0;
                id_fl_int  = 1'b1;
                state_next = HALTED;
            end else if (Jump) begin
                if_fl_int  = 1'b1;
                state_next = RUN;
            end else begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Reset forces a full freeze with bubbles in every stage.
    assign PC_En        = !rst && pc_en_int;
    assign IFid__En     = !rst && if_en_int;
    assign IDex__En     = !rst && id_en_int;
    assign EXmem__En    = !rst && ex_en_int;
    assign MEMwb__En    = !rst && wb_en_int;
    assign IFid__Flush  = rst || if_fl_int;
    assign IDex__Flush  = rst || id_fl_int;
    assign EXmem__Flush = rst || ex_fl_int;
    assign Mem_Err      = !rst && err_int;
    assign Halted       = (state_reg == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    // Index 0: stall cycles, index 1: IF/ID flush cycles. Uses the unmasked
    // responses; the counters are held in reset while rst is high anyway.
    logic [1:0] perf_inc;
    assign perf_inc[0] = !pc_en_int && (state_reg != HALTED);
    assign perf_inc[1] = if_fl_int;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] count_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (perf_inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign Stall_Cnt = g_perf[0].count_reg;
    assign Flush_Cnt = g_perf[1].count_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed, table-driven bench for pipe_ctrl.
// DUT built with MEM_TIMEOUT=4 so the timeout path is reachable quickly.
// Output vector layout (MSB..LSB):
//   PC_En IFid__En IDex__En EXmem__En MEMwb__En
//   IFid__Flush IDex__Flush EXmem__Flush Halted Mem_Err
// Input vector layout: Need_Stall Branch_Taken Jump Mem_Req Mem_Ack Halt Resume
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ns = 1'b0, bt = 1'b0, jp = 1'b0, mreq = 1'b0, mack = 1'b0;
    logic halt = 1'b0, res = 1'b0;
    logic PC_En, IFid__En, IDex__En, EXmem__En, MEMwb__En;
    logic IFid__Flush, IDex__Flush, EXmem__Flush, Halted, Mem_Err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] Stall_Cnt, Flush_Cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .Need_Stall   (ns),
        .Branch_Taken (bt),
        .Jump         (jp),
        .Mem_Req      (mreq),
        .Mem_Ack      (mack),
        .Halt         (halt),
        .Resume       (res),
        .PC_En        (PC_En),
        .IFid__En     (IFid__En),
        .IDex__En     (IDex__En),
        .EXmem__En    (EXmem__En),
        .MEMwb__En    (MEMwb__En),
        .IFid__Flush  (IFid__Flush),
        .IDex__Flush  (IDex__Flush),
        .EXmem__Flush (EXmem__Flush),
        .Halted       (Halted),
        .Mem_Err      (Mem_Err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .Stall_Cnt    (Stall_Cnt),
        .Flush_Cnt    (Flush_Cnt)
`endif
    );

    logic [9:0] act;
    assign act = {PC_En, IFid__En, IDex__En, EXmem__En, MEMwb__En,
                  IFid__Flush, IDex__Flush, EXmem__Flush, Halted, Mem_Err};

    typedef struct {
        logic [6:0] in;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    localparam logic [9:0] O_RUN    = 10'b1_1111_000_00;
    localparam logic [9:0] O_FREEZE = 10'b0_0000_000_00;
    localparam logic [9:0] O_STALL  = 10'b0_0011_001_00;
    localparam logic [9:0] O_BRANCH = 10'b1_1111_110_00;
    localparam logic [9:0] O_JUMP   = 10'b1_1111_100_00;
    localparam logic [9:0] O_HENTER = 10'b0_0111_010_00;
    localparam logic [9:0] O_HALTED = 10'b0_0111_010_10;
    localparam logic [9:0] O_HFRZ   = 10'b0_0100_010_10;
    localparam logic [9:0] O_TMO    = 10'b0_0000_001_01;
    localparam logic [9:0] O_RESET  = 10'b0_0000_111_00;

    task automatic add(input logic [6:0] i, input logic [9:0] e, input string n);
        vec_t v;
        v.in   = i;
        v.exp  = e;
        v.name = n;
        vq.push_back(v);
    endtask

    task automatic set_in(input logic [6:0] v);
        {ns, bt, jp, mreq, mack, halt, res} = v;
    endtask

    // A stage being flushed makes its En irrelevant unless strict is set.
    task automatic check(input string name, input logic [9:0] exp, input bit strict);
        logic [9:0] care;
        care = 10'h3FF;
        if (!strict) begin
            if (exp[4]) care[8] = 1'b0;
            if (exp[3]) care[7] = 1'b0;
            if (exp[2]) care[6] = 1'b0;
        end
        total_cnt++;
        if ((act & care) === (exp & care)) begin
            pass_cnt++;
            $display("ok   %-14s got %b", name, act);
        end else begin
            $display("FAIL %-14s got %b expected %b (care %b)", name, act, exp, care);
        end
    endtask

    task automatic step(input logic [6:0] v, input logic [9:0] exp, input string name);
        @(negedge clk);
        set_in(v);
        #1;
        check(name, exp, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- vector table ------------------------------------------------
        add(7'b0000000, O_RUN,    "idle");
        add(7'b1000000, O_STALL,  "lu_stall");
        add(7'b1000000, O_RUN,    "lu_once");
        add(7'b0000000, O_RUN,    "idle2");
        add(7'b1100000, O_STALL,  "stall_vs_br");
        add(7'b0100000, O_BRANCH, "br_reresolve");
        add(7'b0001000, O_FREEZE, "mw_enter");
        add(7'b0001000, O_FREEZE, "mw_c1");
        add(7'b0001000, O_FREEZE, "mw_c2");
        add(7'b0001100, O_RUN,    "mw_ack");
        add(7'b0000000, O_RUN,    "idle3");
        add(7'b0001000, O_FREEZE, "to_f1");
        add(7'b0001000, O_FREEZE, "to_f2");
        add(7'b0001000, O_FREEZE, "to_f3");
        add(7'b0001000, O_FREEZE, "to_f4");
        add(7'b0001000, O_TMO,    "to_err");
        add(7'b0000000, O_RUN,    "to_after");
        add(7'b0011000, O_FREEZE, "mw_jp_hold");
        add(7'b0011100, O_JUMP,   "mw_jp_rel");
        add(7'b0110000, O_BRANCH, "br_vs_jp");
        add(7'b0010000, O_JUMP,   "jump");
        add(7'b0010010, O_HENTER, "halt_vs_jp");
        add(7'b0000000, O_HALTED, "halted");
        add(7'b0001000, O_HFRZ,   "halt_memfrz");
        add(7'b0000001, O_HALTED, "resume");
        add(7'b0000000, O_RUN,    "after_resume");
        add(7'b0100010, O_BRANCH, "br_vs_halt");
        add(7'b1001000, O_FREEZE, "mem_vs_stall");
        add(7'b1001100, O_STALL,  "rel_stall");
        add(7'b0000000, O_RUN,    "lu_idle");
        add(7'b0001100, O_RUN,    "req_ack_same");

        // ---- reset state -------------------------------------------------
        set_in(7'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset", O_RESET, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // ---- table -------------------------------------------------------
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].in, vq[i].exp, vq[i].name);
        end

        // ---- halt held for 10 cycles, then resume -------------------------
        step(7'b0000010, O_HENTER, "h_enter");
        for (int i = 0; i < 10; i++) begin
            step(7'b0000000, O_HALTED, $sformatf("h_hold%0d", i));
        end
        step(7'b0000001, O_HALTED, "h_resume");
        step(7'b0000000, O_RUN,    "h_released");

        // ---- async reset in the middle of a memory wait -------------------
        step(7'b0001000, O_FREEZE, "rw_enter");
        step(7'b0001000, O_FREEZE, "rw_c1");
        step(7'b0001000, O_FREEZE, "rw_c2");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rw_async_rst", O_RESET, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        set_in(7'b0);
        #1;
        check("rw_release", O_RUN, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        total_cnt++;
        if (Stall_Cnt === 32'd0 && Flush_Cnt === 32'd0) pass_cnt++;
        else $display("FAIL perf_clr got stall=%0d flush=%0d expected 0/0", Stall_Cnt, Flush_Cnt);
`endif
        // Counter must restart from 0: timeout needs the full five cycles.
        step(7'b0001000, O_FREEZE, "rt_f1");
        step(7'b0001000, O_FREEZE, "rt_f2");
        step(7'b0001000, O_FREEZE, "rt_f3");
        step(7'b0001000, O_FREEZE, "rt_f4");
        step(7'b0001000, O_TMO,    "rt_err");
        step(7'b0000000, O_RUN,    "rt_after");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
